// File: rtl/hamming_serial_encoder_if.sv
// Serial in/out handshake bundle for hamming_serial_encoder.
// Ports: din/din_valid/din_ready (input side), dout/dout_valid/dout_ready/dout_last (output side).
interface hamming_serial_encoder_if;
   logic din;
   logic din_valid;
   logic din_ready;
   logic dout;
   logic dout_valid;
   logic dout_ready;
   logic dout_last;

   modport master (
      output din, din_valid, dout_ready,
      input  din_ready, dout, dout_valid, dout_last
   );

   modport slave (
      input  din, din_valid, dout_ready,
      output din_ready, dout, dout_valid, dout_last
   );
endinterface

// File: rtl/hamming_serial_encoder.sv
// Bit-serial Hamming encoder: collects K data bits, computes R parity bits in one cycle,
// streams the codeword out lowest position first.
// Ports: clk, rst (sync, active high), io (slave side of hamming_serial_encoder_if).
// Param R (2..6). Macro SECDED_EN adds overall parity at position 0 (N=2**R, else 2**R-1).
module hamming_serial_encoder #(
   parameter int R = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   hamming_serial_encoder_if.slave  io
);

   localparam int M = 2**R;
`ifdef SECDED_EN
   localparam int N     = M;
   localparam int FIRST = 0;
`else
   localparam int N     = M - 1;
   localparam int FIRST = 1;
`endif
   localparam int K  = M - R - 1;
   localparam int CW = $clog2(N) + 1;

   generate
      if (R < 2 || R > 6) begin : g_bad_r
         $error("hamming_serial_encoder: R must be 2..6");
      end
   endgenerate

   typedef enum logic [1:0] {LOAD, CALC, SEND} state_t;

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cnt;
   logic [R-1:0]    pos;
   logic [R-1:0]    pos_inc;
   logic [R-1:0]    pos_nx;
   logic [R-1:0]    idx;
   logic [M-1:FIRST] mem;
   logic [R-1:0]    par;
   logic            rdy;
   logic            acc;
   logic            last_in;
   logic            last_out;
   logic            dbit;
   logic            dvld;
   logic            dlst;

   assign last_in  = (cnt == CW'(K - 1));
   assign last_out = (cnt == CW'(N - 1));
   assign acc      = rdy & io.din_valid;
   assign idx      = R'(cnt) + R'(FIRST);

   // Next data slot skips the power-of-two parity positions.
   assign pos_inc = pos + 1'b1;
   assign pos_nx  = ((pos_inc & (pos_inc - 1'b1)) == '0) ? pos_inc + 1'b1 : pos_inc;

   always_comb begin
      par = '0;
      for (int i = 0; i < R; i++) begin
         for (int j = 3; j < M; j++) begin
            if (((j & (j - 1)) != 0) && (((j >> i) & 1) == 1)) begin
               par[i] = par[i] ^ mem[j];
            end
         end
      end
   end

`ifdef SECDED_EN
   logic dxor;
   logic ovr;

   // Overall parity covers data plus the freshly computed parity bits.
   always_comb begin
      dxor = 1'b0;
      for (int j = 3; j < M; j++) begin
         if ((j & (j - 1)) != 0) begin
            dxor = dxor ^ mem[j];
         end
      end
      ovr = dxor ^ (^par);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= LOAD;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      rdy      = 1'b0;
      dbit     = 1'b0;
      dvld     = 1'b0;
      dlst     = 1'b0;
      unique case (state)
         LOAD: begin
            rdy = ~rst;
            if (io.din_valid && !rst && last_in) begin
               state_nx = CALC;
            end
         end
         CALC: begin
            state_nx = SEND;
         end
         SEND: begin
            dvld = 1'b1;
            dbit = mem[idx];
            dlst = last_out;
            if (io.dout_ready && last_out) begin
               state_nx = LOAD;
            end
         end
         default: begin
            state_nx = LOAD;
         end
      endcase
   end

   assign io.din_ready  = rdy;
   assign io.dout       = dbit;
   assign io.dout_valid = dvld;
   assign io.dout_last  = dlst;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         pos <= R'(3);
         mem <= '0;
      end else begin
         unique case (state)
            LOAD: begin
               if (acc) begin
                  mem[pos] <= io.din;
                  if (last_in) begin
                     cnt <= '0;
                     pos <= R'(3);
                  end else begin
                     cnt <= cnt + 1'b1;
                     pos <= pos_nx;
                  end
               end
            end
            CALC: begin
               for (int i = 0; i < R; i++) begin
                  mem[1 << i] <= par[i];
               end
`ifdef SECDED_EN
               mem[0] <= ovr;
`endif
            end
            SEND: begin
               if (io.dout_ready) begin
                  cnt <= last_out ? '0 : cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hamming_serial_encoder.sv
// Self-checking bench for hamming_serial_encoder (R=4).
// Honours SECDED_EN the same way as the design.
module tb_hamming_serial_encoder;

   localparam int R = 4;
   localparam int M = 2**R;
`ifdef SECDED_EN
   localparam int N     = M;
   localparam int FIRST = 0;
`else
   localparam int N     = M - 1;
   localparam int FIRST = 1;
`endif
   localparam int K = M - R - 1;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   hamming_serial_encoder_if io ();

   hamming_serial_encoder #(.R(R)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   always #5 clk = ~clk;

   // Reference: place data in non-power-of-two slots, then each parity bit
   // makes its covered group even; optional overall bit makes the whole word even.
   function automatic logic [M-1:0] model(input logic [K-1:0] d);
      logic [M-1:0] cw;
      int           k;
      logic         x;
      cw = '0;
      k  = 0;
      for (int p = 1; p < M; p++) begin
         if ((p & (p - 1)) != 0) begin
            cw[p] = d[k];
            k++;
         end
      end
      for (int i = 0; i < R; i++) begin
         x = 1'b0;
         for (int p = 1; p < M; p++) begin
            if (((p >> i) & 1) == 1 && p != (1 << i)) x = x ^ cw[p];
         end
         cw[1 << i] = x;
      end
`ifdef SECDED_EN
      cw[0] = ^cw[M-1:1];
`endif
      return cw;
   endfunction

   // Called at a negedge with the DUT in LOAD; returns at a negedge in LOAD.
   task automatic run_frame(
      input  logic [K-1:0] data,
      input  logic [M-1:0] cw,
      input  int           gap_pct,
      input  int           stall_pct,
      input  int           stall_at,
      input  string        name,
      output int           cyc
   );
      int   i;
      int   j;
      int   held;
      int   guard;
      logic v;
      logic r;
      i = 0;
      guard = 0;
      cyc = 0;
      while (i < K && guard < 400) begin
         tests++;
         if (io.din_ready !== 1'b1 || io.dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s load bit %0d: din_ready=%b dout_valid=%b, required 1/0",
                     name, i, io.din_ready, io.dout_valid);
         end
         v = ($urandom_range(99) >= gap_pct);
         io.din_valid  = v;
         io.din        = v ? data[i] : 1'($urandom);
         io.dout_ready = 1'($urandom);
         if (v) i++;
         guard++;
         cyc++;
         @(negedge clk);
      end
      tests++;
      if (i < K) begin
         fails++;
         $display("FAIL %s input timeout: accepted %0d, required %0d", name, i, K);
      end
      io.din_valid = 1'($urandom);
      io.din       = 1'($urandom);
      tests++;
      if (io.dout_valid !== 1'b0 || io.din_ready !== 1'b0) begin
         fails++;
         $display("FAIL %s calc: dout_valid=%b din_ready=%b, required 0/0",
                  name, io.dout_valid, io.din_ready);
      end
      cyc++;
      @(negedge clk);
      j = 0;
      held = 0;
      guard = 0;
      while (j < N && guard < 400) begin
         tests++;
         if (io.dout_valid !== 1'b1 || io.dout !== cw[FIRST+j] ||
             io.dout_last !== (j == N - 1) || io.din_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s out bit %0d: v=%b d=%b last=%b rdy=%b, required 1/%b/%b/0",
                     name, j, io.dout_valid, io.dout, io.dout_last, io.din_ready,
                     cw[FIRST+j], (j == N - 1));
         end
         if (j == stall_at && held < 3) begin
            r = 1'b0;
            held++;
         end else begin
            r = ($urandom_range(99) >= stall_pct);
         end
         io.dout_ready = r;
         if (r) j++;
         io.din_valid = (j == N) ? 1'b0 : 1'($urandom);
         io.din       = 1'($urandom);
         guard++;
         cyc++;
         @(negedge clk);
      end
      tests++;
      if (j < N) begin
         fails++;
         $display("FAIL %s output timeout: sent %0d, required %0d", name, j, N);
      end
      tests++;
      if (io.dout_valid !== 1'b0 || io.din_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s return: dout_valid=%b din_ready=%b, required 0/1",
                  name, io.dout_valid, io.din_ready);
      end
      io.dout_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      io.din_valid = 1'b1;
      io.dout_ready = 1'b1;
      repeat (2) @(negedge clk);
      tests++;
      if (io.din_ready !== 1'b0 || io.dout_valid !== 1'b0 ||
          io.dout !== 1'b0 || io.dout_last !== 1'b0) begin
         fails++;
         $display("FAIL reset: rdy=%b v=%b d=%b last=%b, required 0/0/0/0",
                  io.din_ready, io.dout_valid, io.dout, io.dout_last);
      end
      rst = 1'b0;
      io.din_valid = 1'b0;
      io.dout_ready = 1'b0;
      @(negedge clk);
      tests++;
      if (io.din_ready !== 1'b1 || io.dout_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset release: din_ready=%b dout_valid=%b, required 1/0",
                  io.din_ready, io.dout_valid);
      end
   endtask

   task automatic test_vectors();
      int c;
      run_frame('0, '0, 0, 0, -1, "zeros", c);
`ifdef SECDED_EN
      run_frame(11'b1, 16'h000F, 0, 0, -1, "single_one", c);
      run_frame('1, 16'hFFFF, 0, 0, -1, "ones", c);
`else
      run_frame(11'b1, 16'h000E, 0, 0, -1, "single_one", c);
      run_frame('1, 16'hFFFE, 0, 0, -1, "ones", c);
`endif
   endtask

   task automatic test_stall();
      int c;
      logic [K-1:0] d;
      d = K'($urandom);
      run_frame(d, model(d), 0, 0, 5, "stall", c);
   endtask

   task automatic test_reset_midframe();
      int c;
      logic [K-1:0] d;
      for (int i = 0; i < 6; i++) begin
         io.din_valid = 1'b1;
         io.din       = 1'($urandom);
         @(negedge clk);
      end
      rst = 1'b1;
      io.din_valid = 1'b1;
      @(negedge clk);
      tests++;
      if (io.din_ready !== 1'b0 || io.dout_valid !== 1'b0) begin
         fails++;
         $display("FAIL midreset hold: din_ready=%b dout_valid=%b, required 0/0",
                  io.din_ready, io.dout_valid);
      end
      rst = 1'b0;
      io.din_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (io.din_ready !== 1'b1 || io.dout_valid !== 1'b0) begin
         fails++;
         $display("FAIL midreset release: din_ready=%b dout_valid=%b, required 1/0",
                  io.din_ready, io.dout_valid);
      end
      d = K'($urandom);
      run_frame(d, model(d), 0, 0, -1, "midreset_frame", c);
   endtask

   task automatic test_random();
      int c;
      logic [K-1:0] d;
      for (int f = 0; f < 8; f++) begin
         d = K'($urandom);
         run_frame(d, model(d), 30, 30, -1, "random", c);
      end
   endtask

   task automatic test_back_to_back();
      int c;
      logic [K-1:0] d;
      for (int f = 0; f < 3; f++) begin
         d = K'($urandom);
         run_frame(d, model(d), 0, 0, -1, "b2b", c);
         tests++;
         if (c !== K + 1 + N) begin
            fails++;
            $display("FAIL b2b cycles: got %0d, required %0d", c, K + 1 + N);
         end
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      tests = 0;
      fails = 0;
      io.din = 1'b0;
      io.din_valid = 1'b0;
      io.dout_ready = 1'b0;
      test_reset();
      test_vectors();
      test_stall();
      test_reset_midframe();
      test_random();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
